// File: rtl/timer_apb_ctrl.sv
// -----------------------------------------------------------------------------
// timer_apb_ctrl
//
// APB master that runs one complete timer sequence for a single local
// requester. When a start is accepted it:
//   1. writes TCR = 0x2 to hold the counter in clear,
//   2. writes PSC and then ARR,
//   3. writes TCR = 0x1 to enable the counter and release the clear,
//   4. reads TCNT repeatedly until the value reaches the latched target,
//   5. writes TCR = 0x0 to stop the timer, then pulses done.
// An abort lets the transfer in flight finish, skips to the TCR stop write,
// and pulses aborted instead of done.
//
// Timer register map: 0x0 TCR (bit0 en, bit1 clear), 0x4 TCNT (RO),
//                     0x8 PSC, 0xC ARR.
//
// Parameters
//   POLL_GAP    extra idle cycles between two TCNT poll reads. These come on
//               top of the idle cycle that ends every transfer.
//
// Ports
//   PCLK        clock; all logic uses the rising edge
//   PRESET      asynchronous active-high reset
//   start       1-cycle request, sampled only while idle
//   abort       1-cycle request, cancels an active sequence
//   cfg_psc     prescaler value, latched when a start is accepted
//   cfg_arr     auto-reload value, latched when a start is accepted
//   cfg_target  TCNT value that ends the sequence, latched at start
//   busy        high from the accepted start until the return to idle
//   done        1-cycle pulse: target reached and timer stopped
//   aborted     1-cycle pulse: sequence cancelled and timer stopped
//   err         1-cycle pulse: start rejected because target > arr
//   tcnt_last   last TCNT value read over APB
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB master request outputs
//   PRDATA/PREADY                      APB completion inputs from the slave
// -----------------------------------------------------------------------------
module timer_apb_ctrl #(
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_psc,
  input  logic [31:0] cfg_arr,
  input  logic [31:0] cfg_target,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        err,
  output logic [31:0] tcnt_last,
  output logic [3:0]  PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  // Timer register offsets
  localparam logic [3:0] ADDR_TCR  = 4'h0;
  localparam logic [3:0] ADDR_TCNT = 4'h4;
  localparam logic [3:0] ADDR_PSC  = 4'h8;
  localparam logic [3:0] ADDR_ARR  = 4'hC;

  // TCR values written during the sequence
  localparam logic [31:0] TCR_CLEAR  = 32'h0000_0002;
  localparam logic [31:0] TCR_ENABLE = 32'h0000_0001;
  localparam logic [31:0] TCR_STOP   = 32'h0000_0000;

  // The counter must be able to hold POLL_GAP and stay at least one bit wide
  // when POLL_GAP is 0.
  localparam int GW = $clog2(POLL_GAP + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_CLR,
    S_W_PSC,
    S_W_ARR,
    S_W_EN,
    S_POLL,
    S_GAP,
    S_W_STOP
  } state_t;

  // APB phase of the transfer owned by the current state. PH_TAIL is the
  // idle cycle (PSEL=0) that follows every completed transfer. During that
  // cycle 'state' already holds the state whose transfer comes next.
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_ACCESS,
    PH_TAIL
  } phase_t;

  state_t          state;
  phase_t          phase;
  logic [GW-1:0]   gap_cnt;
  logic            abort_pend;
  logic [31:0]     psc_reg;
  logic [31:0]     arr_reg;
  logic [31:0]     target_reg;

  // Combinational decode
  logic   abort_any;   // an abort is pending or arrives this cycle
  logic   cfg_bad;     // start request whose target can never be reached
  logic   launch_req;  // a new SETUP phase begins on the next edge
  state_t launch_st;   // state that owns the transfer being launched
  state_t succ_st;     // state that follows the transfer completing now

  // Address of the transfer owned by a state
  function automatic logic [3:0] addr_of(input state_t s);
    logic [3:0] a;
    case (s)
      S_W_PSC: a = ADDR_PSC;
      S_W_ARR: a = ADDR_ARR;
      S_POLL:  a = ADDR_TCNT;
      default: a = ADDR_TCR;
    endcase
    return a;
  endfunction

  // Write data of the transfer owned by a state. POLL is a read and drives 0.
  function automatic logic [31:0] wdata_of(input state_t s,
                                           input logic [31:0] psc,
                                           input logic [31:0] arr);
    logic [31:0] d;
    case (s)
      S_W_CLR: d = TCR_CLEAR;
      S_W_PSC: d = psc;
      S_W_ARR: d = arr;
      S_W_EN:  d = TCR_ENABLE;
      default: d = TCR_STOP;
    endcase
    return d;
  endfunction

  always_comb begin
    abort_any = abort_pend | abort;
    cfg_bad   = (cfg_target > cfg_arr);

    // Successor of the transfer owned by 'state'. A pending abort redirects
    // every successor to the stop write. The transfer in flight still
    // finishes, because this is only consulted at completion.
    succ_st = S_W_STOP;
    case (state)
      S_W_CLR: succ_st = S_W_PSC;
      S_W_PSC: succ_st = S_W_ARR;
      S_W_ARR: succ_st = S_W_EN;
      S_W_EN:  succ_st = S_POLL;
      S_POLL:  succ_st = (PRDATA >= target_reg) ? S_W_STOP : S_GAP;
      default: succ_st = S_W_STOP;
    endcase
    if (abort_any) begin
      succ_st = S_W_STOP;
    end

    // New transfers start from three places: an accepted start in IDLE, the
    // end of the poll gap, and the idle cycle after any other transfer.
    launch_req = 1'b0;
    launch_st  = state;
    case (state)
      S_IDLE: begin
        // An abort in the same cycle as start is ignored here.
        launch_req = start & ~cfg_bad;
        launch_st  = S_W_CLR;
      end
      S_GAP: begin
        launch_req = abort_any | (gap_cnt == '0);
        launch_st  = abort_any ? S_W_STOP : S_POLL;
      end
      default: begin
        launch_req = (phase == PH_TAIL);
        launch_st  = abort_any ? S_W_STOP : state;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= S_IDLE;
      phase      <= PH_SETUP;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
      psc_reg    <= '0;
      arr_reg    <= '0;
      target_reg <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      err        <= 1'b0;
      tcnt_last  <= '0;
      PADDR      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;

      // Cleared again below if the sequence ends on this same edge.
      if (busy && abort) begin
        abort_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              psc_reg    <= cfg_psc;
              arr_reg    <= cfg_arr;
              target_reg <= cfg_target;
              busy       <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (!launch_req) begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          case (phase)
            PH_SETUP: begin
              PENABLE <= 1'b1;
              phase   <= PH_ACCESS;
            end

            PH_ACCESS: begin
              // ACCESS is held for as long as the slave stalls.
              if (PREADY) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                if (state == S_POLL) begin
                  tcnt_last <= PRDATA;
                end
                if (state == S_W_STOP) begin
                  // IDLE itself provides the idle cycle after this transfer.
                  state      <= S_IDLE;
                  phase      <= PH_SETUP;
                  busy       <= 1'b0;
                  abort_pend <= 1'b0;
                  if (abort_any) begin
                    aborted <= 1'b1;
                  end else begin
                    done <= 1'b1;
                  end
                end else if (succ_st == S_GAP) begin
                  // The first GAP cycle doubles as the post-transfer idle
                  // cycle. POLL_GAP more follow before the next poll.
                  state   <= S_GAP;
                  gap_cnt <= GW'(POLL_GAP);
                end else begin
                  state <= succ_st;
                  phase <= PH_TAIL;
                end
              end
            end

            default: begin
              // PH_TAIL: the launch block below starts the next SETUP.
            end
          endcase
        end
      endcase

      // Launch a new transfer. Address, direction and data are loaded once
      // here and stay unchanged through SETUP and ACCESS.
      if (launch_req) begin
        state   <= launch_st;
        phase   <= PH_SETUP;
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PADDR   <= addr_of(launch_st);
        PWRITE  <= (launch_st != S_POLL);
        PWDATA  <= wdata_of(launch_st, psc_reg, arr_reg);
      end
    end
  end

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_apb_ctrl
//
// Directed testbench for timer_apb_ctrl. The stimulus process queues the
// APB transfers and end-of-sequence pulses each test should produce. Monitor
// processes check every completed APB transfer and every done/aborted/err
// pulse against those queues. A protocol monitor checks the SETUP/ACCESS
// timing and signal stability on every transfer.
//
// The APB slave model returns registered PREADY after a configurable number
// of wait states. TCNT reads return values from a per-test script, so the
// number of poll reads is fixed by hand for each test.
// -----------------------------------------------------------------------------
module tb_timer_apb_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        start;
  logic        abort;
  logic [31:0] cfg_psc;
  logic [31:0] cfg_arr;
  logic [31:0] cfg_target;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        err;
  logic [31:0] tcnt_last;
  logic [3:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  always #5 PCLK = ~PCLK;

  timer_apb_ctrl #(.POLL_GAP(4)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .start      (start),
    .abort      (abort),
    .cfg_psc    (cfg_psc),
    .cfg_arr    (cfg_arr),
    .cfg_target (cfg_target),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .err        (err),
    .tcnt_last  (tcnt_last),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY)
  );

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct packed {
    logic [2:0]  kind;   // {err, aborted, done}
    logic [31:0] tcnt;
  } evt_t;

  localparam logic [2:0] EV_DONE  = 3'b001;
  localparam logic [2:0] EV_ABORT = 3'b010;
  localparam logic [2:0] EV_ERR   = 3'b100;

  xfer_t       exp_x[$];
  evt_t        exp_e[$];
  logic [31:0] rd_script[$];
  int          waits = 0;
  int          wcnt;
  int          reads_done = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- APB slave (registered PREADY) ----------------
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
      wcnt   <= 0;
    end else if (PSEL && PENABLE) begin
      if (PREADY) begin
        PREADY <= 1'b0;
        wcnt   <= 0;
      end else if (wcnt >= waits) begin
        PREADY <= 1'b1;
        if (!PWRITE) begin
          rv = (rd_script.size() > 0) ? rd_script.pop_front() : 32'hFFFF_FFFF;
          PRDATA <= rv;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // ---------------- transfer scoreboard ----------------
  always @(negedge PCLK) begin
    xfer_t e;
    if (!PRESET && PSEL && PENABLE && PREADY) begin
      $display("xfer %s addr=0x%h data=0x%08h", PWRITE ? "WR" : "RD", PADDR,
               PWRITE ? PWDATA : PRDATA);
      if (!PWRITE) reads_done++;
      if (exp_x.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL xfer_unexpected: got addr 0x%h wr %b, expected no transfer", PADDR, PWRITE);
      end else begin
        e = exp_x.pop_front();
        check("xfer_dir", 32'(PWRITE), 32'(e.wr));
        check("xfer_addr", 32'(PADDR), 32'(e.addr));
        if (e.wr) check("xfer_wdata", PWDATA, e.data);
      end
    end
  end

  // ---------------- pulse scoreboard ----------------
  always @(negedge PCLK) begin
    evt_t e;
    if (!PRESET && (done || aborted || err)) begin
      $display("event done=%b aborted=%b err=%b tcnt_last=0x%08h", done, aborted, err, tcnt_last);
      if (exp_e.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL evt_unexpected: got {err,aborted,done}=%b, expected no pulse", {err, aborted, done});
      end else begin
        e = exp_e.pop_front();
        check("evt_kind", 32'({err, aborted, done}), 32'(e.kind));
        check("evt_busy", 32'(busy), 32'd0);
        if (e.kind != EV_ERR) check("evt_tcnt", tcnt_last, e.tcnt);
      end
    end
  end

  // ---------------- APB protocol monitor ----------------
  logic        pv_psel, pv_pen, pv_rdy, pv_wr;
  logic [3:0]  pv_addr;
  logic [31:0] pv_wd;

  always @(negedge PCLK) begin
    if (PRESET) begin
      pv_psel = 1'b0;
      pv_pen  = 1'b0;
      pv_rdy  = 1'b0;
      pv_wr   = 1'b0;
      pv_addr = '0;
      pv_wd   = '0;
    end else begin
      if (pv_psel && (!pv_pen || !pv_rdy)) begin
        // After SETUP, or an ACCESS with PREADY low, the next cycle must be
        // ACCESS with unchanged request signals.
        check("apb_hold", 32'({PSEL, PENABLE, PADDR, PWRITE}), 32'({2'b11, pv_addr, pv_wr}));
        check("apb_wdata_stable", PWDATA, pv_wd);
      end
      if (pv_psel && pv_pen && pv_rdy) begin
        check("apb_post_idle", 32'({PSEL, PENABLE}), 32'd0);
      end
      pv_psel = PSEL;
      pv_pen  = PENABLE;
      pv_rdy  = PREADY;
      pv_wr   = PWRITE;
      pv_addr = PADDR;
      pv_wd   = PWDATA;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic push_w(input logic [3:0] a, input logic [31:0] d);
    exp_x.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic push_r(input int n);
    for (int i = 0; i < n; i++) exp_x.push_back('{wr: 1'b0, addr: 4'h4, data: 32'h0});
  endtask

  task automatic push_cfg(input logic [31:0] psc, input logic [31:0] arr);
    push_w(4'h0, 32'h2);
    push_w(4'h8, psc);
    push_w(4'hC, arr);
    push_w(4'h0, 32'h1);
  endtask

  task automatic push_e(input logic [2:0] k, input logic [31:0] t);
    exp_e.push_back('{kind: k, tcnt: t});
  endtask

  task automatic do_start(input logic [31:0] psc, input logic [31:0] arr,
                          input logic [31:0] tgt, input logic with_abort);
    @(negedge PCLK);
    cfg_psc    = psc;
    cfg_arr    = arr;
    cfg_target = tgt;
    start      = 1'b1;
    abort      = with_abort;
    @(negedge PCLK);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int max);
    int k = 0;
    while ((exp_x.size() != 0 || exp_e.size() != 0 || busy) && k < max) begin
      @(negedge PCLK);
      #2;
      k++;
    end
    check(name, 32'(exp_x.size() + exp_e.size()), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int rd_base;
    int seen;
    PRESET     = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_psc    = '0;
    cfg_arr    = '0;
    cfg_target = '0;
    cyc(3);
    PRESET = 1'b0;
    cyc(1);

    // Reset state
    check("rst_flags", 32'({busy, done, aborted, err, PSEL, PENABLE, PWRITE}), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_tcnt", tcnt_last, 32'd0);

    // 1: basic sequence, three polls (1, 3, 6) against target 5
    rd_script = '{32'd1, 32'd3, 32'd6};
    push_cfg(32'd0, 32'd20);
    push_r(3);
    push_w(4'h0, 32'h0);
    push_e(EV_DONE, 32'd6);
    do_start(32'd0, 32'd20, 32'd5, 1'b0);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    wait_quiet("t1_drain", 400);

    // 2: three wait states, unsigned compare above bit 31, target equal to TCNT
    waits = 3;
    rd_script = '{32'h7FFF_FFFF, 32'h8000_0000};
    push_cfg(32'd7, 32'hFFFF_FFFF);
    push_r(2);
    push_w(4'h0, 32'h0);
    push_e(EV_DONE, 32'h8000_0000);
    do_start(32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    wait_quiet("t2_drain", 600);
    waits = 0;

    // 3: target beyond ARR is rejected with err and no APB activity
    push_e(EV_ERR, 32'd0);
    do_start(32'd0, 32'd3, 32'd7, 1'b0);
    seen = 0;
    repeat (12) begin
      @(negedge PCLK);
      if (PSEL) seen++;
    end
    check("t3_no_psel", 32'(seen), 32'd0);
    wait_quiet("t3_drain", 50);

    // 4: target 0 finishes on the first poll. A start while busy is ignored.
    rd_script = '{32'd0};
    push_cfg(32'd1, 32'd10);
    push_r(1);
    push_w(4'h0, 32'h0);
    push_e(EV_DONE, 32'd0);
    do_start(32'd1, 32'd10, 32'd0, 1'b0);
    cyc(6);
    check("t4_busy_mid", 32'(busy), 32'd1);
    do_start(32'd5, 32'd3, 32'd7, 1'b0);
    wait_quiet("t4_drain", 400);

    // 5a: abort while idle does nothing
    @(negedge PCLK);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    cyc(4);
    check("t5_idle_abort_busy", 32'(busy), 32'd0);

    // 5b: abort during the second poll ACCESS
    rd_script = '{32'd1, 32'd2};
    push_cfg(32'd2, 32'd50);
    push_r(2);
    push_w(4'h0, 32'h0);
    push_e(EV_ABORT, 32'd2);
    rd_base = reads_done;
    do_start(32'd2, 32'd50, 32'd40, 1'b0);
    k = 0;
    while (!(PSEL && PENABLE && !PWRITE && reads_done == rd_base + 1) && k < 400) begin
      @(negedge PCLK);
      k++;
    end
    check("t5_found_2nd_poll", 32'(k < 400), 32'd1);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    wait_quiet("t5_drain", 400);

    // 6: PRESET during the ARR write ACCESS
    rd_script = {};
    push_w(4'h0, 32'h2);
    push_w(4'h8, 32'd0);
    do_start(32'd0, 32'd20, 32'd5, 1'b0);
    k = 0;
    while (!(PSEL && PENABLE && PADDR == 4'hC) && k < 200) begin
      @(negedge PCLK);
      k++;
    end
    check("t6_found_arr_access", 32'(k < 200), 32'd1);
    #1 PRESET = 1'b1;
    #1;
    check("t6_rst_flags", 32'({busy, done, aborted, err, PSEL, PENABLE, PWRITE}), 32'd0);
    check("t6_rst_paddr", 32'(PADDR), 32'd0);
    check("t6_rst_pwdata", PWDATA, 32'd0);
    check("t6_rst_tcnt", tcnt_last, 32'd0);
    cyc(2);
    PRESET = 1'b0;
    check("t6_pending_after_rst", 32'(exp_x.size()), 32'd0);

    // 6b: fresh run after reset, start and abort together (abort ignored)
    rd_script = '{32'd9};
    push_cfg(32'd0, 32'd20);
    push_r(1);
    push_w(4'h0, 32'h0);
    push_e(EV_DONE, 32'd9);
    do_start(32'd0, 32'd20, 32'd5, 1'b1);
    wait_quiet("t6_drain", 400);

    cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
